zvc_packer: RTL and testbench

- Downstream stage of the 32-lane prefix adder in the zero-value-compression (ZVC) path.
- Takes one 32-word line, its nonzero mask and the per-lane inclusive prefix counts produced by the prefix adder. It scatters the nonzero words into a dense buffer.
- Streams the compressed line out as one header beat followed by packed payload beats, using valid/ready handshakes on both sides.

---
 rtl/zvc_packer.sv | 157 +++++++++++++++
 tb/tb_zvc_packer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/zvc_packer.sv
// ZVC packer: scatters the nonzero lanes of a 32-word line into a dense buffer,
// then streams a header beat followed by packed payload beats.
module zvc_packer #(
    parameter int WORD_W     = 32,
    parameter int BEAT_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [32*WORD_W-1:0]         in_data,
    input  logic [31:0]                  in_mask,
    input  logic [1023:0]                in_psum,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BEAT_WORDS*WORD_W-1:0] out_data,
    output logic                         out_header,
    output logic                         out_last
);

    localparam int OW = BEAT_WORDS * WORD_W;
    localparam int SH = $clog2(BEAT_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAY
    } state_t;

    state_t                   state_q, state_d;
    logic [31:0][WORD_W-1:0]  dense_q, dense_d;
    logic [31:0]              mask_q, mask_d;
    logic [5:0]               nnz_q, nnz_d;
    logic [5:0]               beat_q, beat_d;

    logic [31:0][WORD_W-1:0]  scat;
    logic [5:0]               in_nnz;
    logic [6:0]               nb;
    logic                     last_pay;
    logic [OW-1:0]            hdr;
    logic [OW-1:0]            pay;
    logic                     unused_psum;

    // Only the low count bits of each lane are meaningful to the scatter.
    assign unused_psum = ^in_psum;
    assign in_nnz      = in_psum[31*32 +: 6];

    // Inclusive count minus one, taken mod 32, is the dense slot of a kept lane.
    always_comb begin
        logic [4:0] pidx;
        scat = '0;
        pidx = '0;
        for (int i = 0; i < 32; i++) begin
            pidx = in_psum[i*32 +: 5] - 5'd1;
            if (in_mask[i]) begin
                scat[pidx] = in_data[i*WORD_W +: WORD_W];
            end
        end
        for (int j = 0; j < 32; j++) begin
            if (6'(j) >= in_nnz) begin
                scat[j] = '0;
            end
        end
    end

    assign nb       = ({1'b0, nnz_q} + 7'(BEAT_WORDS - 1)) >> SH;
    assign last_pay = ({1'b0, beat_q} == (nb - 7'd1));

    always_comb begin
        hdr        = '0;
        hdr[31:0]  = mask_q;
        hdr[37:32] = nnz_q;
    end

    always_comb begin
        logic [6:0] widx;
        pay  = '0;
        widx = '0;
        for (int k = 0; k < BEAT_WORDS; k++) begin
            widx = {1'b0, beat_q} * 7'(BEAT_WORDS) + 7'(k);
            if (widx < {1'b0, nnz_q}) begin
                pay[k*WORD_W +: WORD_W] = dense_q[widx[4:0]];
            end
        end
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q != S_IDLE);
        out_header = (state_q == S_HDR);
        out_last   = 1'b0;
        out_data   = '0;
        unique case (state_q)
            S_HDR: begin
                out_last = (nnz_q == 6'd0);
                out_data = hdr;
            end
            S_PAY: begin
                out_last = last_pay;
                out_data = pay;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dense_d = dense_q;
        mask_d  = mask_q;
        nnz_d   = nnz_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dense_d = scat;
                    mask_d  = in_mask;
                    nnz_d   = in_nnz;
                    beat_d  = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (out_ready) begin
                    beat_d  = '0;
                    state_d = (nnz_q == 6'd0) ? S_IDLE : S_PAY;
                end
            end
            S_PAY: begin
                if (out_ready) begin
                    if (last_pay) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dense_q <= '0;
            mask_q  <= '0;
            nnz_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            dense_q <= dense_d;
            mask_q  <= mask_d;
            nnz_q   <= nnz_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_zvc_packer.sv
// Directed bench for zvc_packer: sparse, zero, dense, stalled,
// back-to-back lines and reset during payload.
module tb_zvc_packer;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_data;
    logic [31:0]   in_mask;
    logic [1023:0] in_psum;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic          out_header;
    logic          out_last;

    int checks = 0;
    int errs   = 0;

    zvc_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mask    (in_mask),
        .in_psum    (in_psum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_header (out_header),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] m, input int base);
        int cnt;
        cnt = 0;
        in_mask = m;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) cnt++;
            in_psum[i*32 +: 32] = cnt;
            in_data[i*32 +: 32] = base + i;
        end
    endtask

    task automatic send(input string tag, input logic [31:0] m,
                        input int base);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        load(m, base);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] hdrw(input logic [31:0] m,
                                          input logic [5:0] n);
        logic [127:0] h;
        h = '0;
        h[31:0]  = m;
        h[37:32] = n;
        return h;
    endfunction

    task automatic beat(input string tag, input logic hd, input logic lst,
                        input logic [127:0] d, input logic stall);
        if (stall) begin
            out_ready = 1'b0;
            chk({tag, "_valid"}, 128'(out_valid), 128'd1);
            chk({tag, "_data"}, out_data, d);
            @(negedge clk);
            chk({tag, "_hold_data"}, out_data, d);
            chk({tag, "_hold_hdr"}, 128'(out_header), 128'(hd));
            chk({tag, "_hold_last"}, 128'(out_last), 128'(lst));
            chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        chk({tag, "_valid"}, 128'(out_valid), 128'd1);
        chk({tag, "_hdr"}, 128'(out_header), 128'(hd));
        chk({tag, "_last"}, 128'(out_last), 128'(lst));
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd0);
        @(negedge clk);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_out_data"}, out_data, 128'd0);
    endtask

    localparam logic [31:0] SPARSE = 32'h0808_2013;
    localparam logic [127:0] SP_B0 = {32'd14, 32'd5, 32'd2, 32'd1};
    localparam logic [127:0] SP_B1 = {32'd0, 32'd0, 32'd28, 32'd20};

    initial begin
        logic [127:0] d;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_mask   = '0;
        in_psum   = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        idle_chk("reset");
        chk("reset_hdr", 128'(out_header), 128'd0);
        chk("reset_last", 128'(out_last), 128'd0);

        send("sp", SPARSE, 1);
        beat("sp_hdr", 1'b1, 1'b0, hdrw(SPARSE, 6'd6), 1'b0);
        beat("sp_b0", 1'b0, 1'b0, SP_B0, 1'b0);
        beat("sp_b1", 1'b0, 1'b1, SP_B1, 1'b0);
        idle_chk("sp_done");

        send("zero", 32'h0, 1);
        beat("zero_hdr", 1'b1, 1'b1, hdrw(32'h0, 6'd0), 1'b0);
        idle_chk("zero_done");

        send("dense", 32'hFFFF_FFFF, 32'h100);
        beat("dense_hdr", 1'b1, 1'b0, hdrw(32'hFFFF_FFFF, 6'd32), 1'b0);
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'h100 + 4*b + k;
            beat($sformatf("dense_b%0d", b), 1'b0, (b == 7), d, 1'b0);
        end
        idle_chk("dense_done");

        send("bp", SPARSE, 1);
        beat("bp_hdr", 1'b1, 1'b0, hdrw(SPARSE, 6'd6), 1'b1);
        beat("bp_b0", 1'b0, 1'b0, SP_B0, 1'b1);
        beat("bp_b1", 1'b0, 1'b1, SP_B1, 1'b1);
        idle_chk("bp_done");

        send("rst", 32'hFFFF_FFFF, 32'h100);
        beat("rst_hdr", 1'b1, 1'b0, hdrw(32'hFFFF_FFFF, 6'd32), 1'b0);
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'h100 + k;
        beat("rst_b0", 1'b0, 1'b0, d, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        idle_chk("rst_rel");
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rst_stale%0d", c), 128'(out_valid), 128'd0);
            @(negedge clk);
        end

        load(SPARSE, 1);
        chk("b2b_in_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        @(negedge clk);
        load(32'h8000_0001, 1);
        beat("b2b_hdr1", 1'b1, 1'b0, hdrw(SPARSE, 6'd6), 1'b0);
        beat("b2b_b0", 1'b0, 1'b0, SP_B0, 1'b0);
        beat("b2b_b1", 1'b0, 1'b1, SP_B1, 1'b0);
        chk("b2b_gap_ready", 128'(in_ready), 128'd1);
        chk("b2b_gap_valid", 128'(out_valid), 128'd0);
        @(negedge clk);
        in_valid = 1'b0;
        beat("b2b_hdr2", 1'b1, 1'b0, hdrw(32'h8000_0001, 6'd2), 1'b0);
        beat("b2b_l2b0", 1'b0, 1'b1, {32'd0, 32'd0, 32'd32, 32'd1}, 1'b0);
        idle_chk("b2b_done");

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
